// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_adder_if
// Description : Operand/result handshake bundle for pipelined_cla_adder.
//               master = producer/consumer side, slave = adder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_adder
// Description : Add/subtract unit built from 4-bit carry-lookahead groups,
//               split into STAGES slices, one slice resolved per pipeline
//               rank, with valid/ready flow control on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    pipelined_cla_adder_if.slave   bus
);
    // Bits resolved per rank and 4-bit lookahead groups per slice.
    localparam int SW   = WIDTH / STAGES;
    localparam int NGRP = SW / 4;

    // Slice adder: group propagate/generate inside each 4-bit group, group
    // carries chained through the group P/G terms. Returns {carry_out, sum}.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                               input logic [SW-1:0] b,
                                               input logic          c);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] s;
        logic [3:0]    gp;
        logic [3:0]    gg;
        logic [3:0]    cb;
        logic          grp_p;
        logic          grp_g;
        logic          cg;
        p  = a ^ b;
        g  = a & b;
        cg = c;
        for (int n = 0; n < NGRP; n++) begin
            gp    = p[n*4 +: 4];
            gg    = g[n*4 +: 4];
            cb[0] = cg;
            cb[1] = gg[0] | (gp[0] & cg);
            cb[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg);
            cb[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                  | (gp[2] & gp[1] & gp[0] & cg);
            grp_p = &gp;
            grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0]);
            s[n*4 +: 4] = gp ^ cb;
            cg = grp_g | (grp_p & cg);
        end
        return {cg, s};
    endfunction

    // Per-rank state: operands travel with the beat so later slices see
    // delay-matched bits; finished sum bits ride along in s_q.
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              c_q [STAGES];

    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              c_d [STAGES];

    logic [STAGES:0]   w_rdy;
    logic [WIDTH-1:0]  w_src_s [STAGES];
    logic              w_src_c [STAGES];
    logic [SW:0]       w_slice [STAGES];

    // Rank k may load when it is empty or its contents move on this edge.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = ~valid_q[k] | w_rdy[k+1];
        end
    end

    // Next-state for every rank: rank 0 takes the (possibly inverted) bus
    // operands, rank k>0 continues the beat held in rank k-1.
    always_comb begin
        valid_d    = '0;
        a_d[0]     = bus.in1;
        b_d[0]     = bus.sub ? ~bus.in2 : bus.in2;
        w_src_s[0] = '0;
        w_src_c[0] = bus.sub ? 1'b1 : bus.cin;
        valid_d[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            w_src_s[k] = s_q[k-1];
            w_src_c[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k]           = cla_slice(a_d[k][k*SW +: SW], b_d[k][k*SW +: SW], w_src_c[k]);
            s_d[k]               = w_src_s[k];
            s_d[k][k*SW +: SW]   = w_slice[k][SW-1:0];
            c_d[k]               = w_slice[k][SW];
        end
    end

    // Pipeline ranks; data only loads with a valid beat so a stalled or
    // drained output keeps its last result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        a_q[k] <= a_d[k];
                        b_q[k] <= b_d[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
        end
    end

    // Result flags come straight off the last rank so they stay aligned
    // with sum; reset_n gates in_ready so nothing is accepted in reset.
    assign bus.in_ready  = reset_n & w_rdy[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.overflow  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                         & (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    assign bus.zero      = valid_q[STAGES-1] & ~(|s_q[STAGES-1]);

endmodule
`default_nettype wire
